serial_add_ctrl: RTL and testbench

- Bit-serial N-bit adder controller: sequences a single instance of the team's existing 1-bit full adder cell (fa_dataflow) over WIDTH cycles, LSB first.
- Operands are captured on a start handshake. The carry is held in a register between bits. Sum and carry-out are published with a one-cycle done pulse.
- Serves as the area-minimal adder for the practice datapath.

---
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell stepped over WIDTH cycles,
// LSB first, with a registered carry and a one-cycle completion pulse.

module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             fa_s, fa_co;

    fa_dataflow u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Operand A's register doubles as the result shift register: each sum
    // bit enters at the MSB as the consumed operand bit leaves at the LSB.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d  = {fa_s, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = {fa_s, a_sh_q[WIDTH-1:1]};
                    co_d    = fa_co;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign co   = co_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2; expected sums
// come from plain integer addition and are checked by per-instance monitors.

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start8, ci8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;
    logic       start2, ci2, busy2, done2, co2;
    logic [1:0] a2, b2, s2;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .ci(ci8), .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
        .ci(ci2), .busy(busy2), .done(done2), .s(s2), .co(co2)
    );

    logic [8:0] q8[$];
    logic [2:0] q2[$];
    logic [8:0] last8 = '0;
    logic [2:0] last2 = '0;
    logic       prev_done8 = 1'b0;
    logic       prev_done2 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop on every done pulse, otherwise outputs must hold.
    always @(negedge clk) begin
        if (armed) begin
            if (done8) begin
                chk("done8_single", 32'(prev_done8), 32'd0);
                if (q8.size() == 0) begin
                    chk("done8_expected", 32'd1, 32'd0);
                end else begin
                    last8 = q8.pop_front();
                    chk("sum8", 32'({co8, s8}), 32'(last8));
                end
            end else begin
                chk("hold8", 32'({co8, s8}), 32'(last8));
            end
            prev_done8 = done8;
            if (!rst_n) begin
                last8 = '0;
                prev_done8 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (done2) begin
                chk("done2_single", 32'(prev_done2), 32'd0);
                if (q2.size() == 0) begin
                    chk("done2_expected", 32'd1, 32'd0);
                end else begin
                    last2 = q2.pop_front();
                    chk("sum2", 32'({co2, s2}), 32'(last2));
                end
            end else begin
                chk("hold2", 32'({co2, s2}), 32'(last2));
            end
            prev_done2 = done2;
            if (!rst_n) begin
                last2 = '0;
                prev_done2 = 1'b0;
            end
        end
    end

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tci, input bit chg, input bit noise);
        int  lat;
        int  bc;
        bit  hit;
        @(posedge clk) #1;
        start8 = 1'b1; a8 = ta; b8 = tb; ci8 = tci;
        q8.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tci});
        @(posedge clk) #1;
        start8 = 1'b0;
        if (chg) begin
            a8 = 8'hFF; b8 = 8'hFF; ci8 = ~tci;
        end
        lat = 0; bc = 0; hit = 1'b0;
        while (lat < 30 && !hit) begin
            if (noise) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            end
            @(negedge clk);
            lat++;
            if (busy8) bc++;
            if (done8) hit = 1'b1;
            else @(posedge clk) #1;
        end
        chk("done8_seen", 32'(hit), 32'd1);
        chk("latency8", 32'(lat), 32'd9);
        chk("busy8_cycles", 32'(bc), 32'd8);
        @(posedge clk) #1;
        start8 = 1'b0;
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tb,
                        input logic tci, input bit noise);
        int  lat;
        int  bc;
        bit  hit;
        @(posedge clk) #1;
        start2 = 1'b1; a2 = ta; b2 = tb; ci2 = tci;
        q2.push_back({1'b0, ta} + {1'b0, tb} + {2'd0, tci});
        @(posedge clk) #1;
        start2 = 1'b0;
        lat = 0; bc = 0; hit = 1'b0;
        while (lat < 30 && !hit) begin
            if (noise) begin
                start2 = 1'($urandom_range(0, 1));
                a2 = 2'($urandom); b2 = 2'($urandom); ci2 = 1'($urandom);
            end
            @(negedge clk);
            lat++;
            if (busy2) bc++;
            if (done2) hit = 1'b1;
            else @(posedge clk) #1;
        end
        chk("done2_seen", 32'(hit), 32'd1);
        chk("latency2", 32'(lat), 32'd3);
        chk("busy2_cycles", 32'(bc), 32'd2);
        @(posedge clk) #1;
        start2 = 1'b0;
    endtask

    initial begin
        int nd;
        int t[3];
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'({co8, s8}), 32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);
        chk("rst_done2", 32'(done2), 32'd0);
        chk("rst_sum2", 32'({co2, s2}), 32'd0);
        armed = 1'b1;

        run8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run8(8'h3C, 8'h0F, 1'b0, 1'b1, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);

        // Start held high: three back-to-back operations, no extras.
        @(posedge clk) #1;
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
        repeat (3) q8.push_back(9'h002);
        nd = 0;
        t = '{0, 0, 0};
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (done8) begin
                t[nd] = cyc;
                nd++;
            end
        end
        @(posedge clk) #1;
        start8 = 1'b0;
        chk("held_count", 32'(nd), 32'd3);
        chk("held_period_a", 32'(t[1] - t[0]), 32'd10);
        chk("held_period_b", 32'(t[2] - t[1]), 32'd10);
        repeat (15) @(posedge clk);
        chk("held_queue_empty", 32'(q8.size()), 32'd0);

        // Reset while bit 4 is about to be processed.
        @(posedge clk) #1;
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; ci8 = 1'b1;
        @(posedge clk) #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_s", 32'(s8), 32'd0);
        chk("mid_rst_co", 32'(co8), 32'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk("mid_rst_no_done", 32'(nd), 32'd0);
        run8(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b1);

        run2(2'b11, 2'b11, 1'b1, 1'b0);
        run2(2'b00, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++)
            run2(2'($urandom), 2'($urandom), 1'($urandom), 1'b1);

        repeat (5) @(posedge clk);
        chk("final_queue8", 32'(q8.size()), 32'd0);
        chk("final_queue2", 32'(q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
